// File: rtl/regfile_sb_if.sv
// regfile_sb_if: read, write and scoreboard signals of the register file
interface regfile_sb_if #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] addrA, addrB;
    logic [XLEN-1:0]   dataA, dataB;
    logic              busyA, busyB;
    logic              w0En, w1En, allocEn;
    logic [ADDR_W-1:0] w0Addr, w1Addr, allocAddr;
    logic [XLEN-1:0]   w0Data, w1Data;
    logic              anyBusy;
    logic [ADDR_W:0]   busyCnt;
    modport master (
        output addrA, addrB, w0En, w0Addr, w0Data, w1En, w1Addr, w1Data, allocEn, allocAddr,
        input  dataA, dataB, busyA, busyB, anyBusy, busyCnt
    );
    modport slave (
        input  addrA, addrB, w0En, w0Addr, w0Data, w1En, w1Addr, w1Data, allocEn, allocAddr,
        output dataA, dataB, busyA, busyB, anyBusy, busyCnt
    );
endinterface

// File: rtl/regfile_sb.sv
// regfile_sb: 2-read/2-write register file with optional write bypass and a load scoreboard
module regfile_sb #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 5,
    parameter bit BYPASS = 1'b1
) (
    input logic         clk,
    input logic         rst_n,
    regfile_sb_if.slave bus
);
    localparam int NREG = 2 ** ADDR_W;
    logic [XLEN-1:0] regs [NREG];
    logic [NREG-1:0] busy, busy_nxt;
    logic [ADDR_W:0] cnt;
    logic            set_new, clr_old;
    function automatic logic [XLEN-1:0] rd(input logic [ADDR_W-1:0] a);
        return (a == '0) ? '0 :
               (BYPASS && bus.w0En && bus.w0Addr == a) ? bus.w0Data :
               (BYPASS && bus.w1En && bus.w1Addr == a) ? bus.w1Data : regs[a];
    endfunction
    always_comb begin
        busy_nxt = busy;
        if (bus.w1En) busy_nxt[bus.w1Addr] = 1'b0;
        if (bus.allocEn) busy_nxt[bus.allocAddr] = 1'b1;
        busy_nxt[0] = 1'b0;
    end
    // count only real transitions so busyCnt mirrors the popcount of busy
    assign set_new = bus.allocEn && bus.allocAddr != '0 && !busy[bus.allocAddr];
    assign clr_old = bus.w1En && bus.w1Addr != '0 && busy[bus.w1Addr] &&
                     !(bus.allocEn && bus.allocAddr == bus.w1Addr);
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
            busy <= '0;
            cnt  <= '0;
        end else begin
            if (bus.w1En && bus.w1Addr != '0) regs[bus.w1Addr] <= bus.w1Data;
            if (bus.w0En && bus.w0Addr != '0) regs[bus.w0Addr] <= bus.w0Data;
            busy <= busy_nxt;
            cnt  <= cnt + (ADDR_W+1)'(set_new) - (ADDR_W+1)'(clr_old);
        end
    end
    assign bus.dataA   = rd(bus.addrA);
    assign bus.dataB   = rd(bus.addrB);
    assign bus.busyA   = busy[bus.addrA] & ~(BYPASS & bus.w1En & (bus.w1Addr == bus.addrA));
    assign bus.busyB   = busy[bus.addrB] & ~(BYPASS & bus.w1En & (bus.w1Addr == bus.addrB));
    assign bus.anyBusy = cnt != '0;
    assign bus.busyCnt = cnt;
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed and random checks of regfile_sb (BYPASS=1 and BYPASS=0) against a model
module tb_regfile_sb;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int total = 0;
    int bad = 0;
    logic [31:0] m_reg [32];
    logic [31:0] m_busy;
    always #5 clk = ~clk;
    regfile_sb_if #(.XLEN(32), .ADDR_W(5)) bus ();
    regfile_sb_if #(.XLEN(32), .ADDR_W(5)) nb ();
    regfile_sb #(.XLEN(32), .ADDR_W(5), .BYPASS(1'b1)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    regfile_sb #(.XLEN(32), .ADDR_W(5), .BYPASS(1'b0)) dut_nb (.clk(clk), .rst_n(rst_n), .bus(nb));
    assign nb.addrA     = bus.addrA;
    assign nb.addrB     = bus.addrB;
    assign nb.w0En      = bus.w0En;
    assign nb.w0Addr    = bus.w0Addr;
    assign nb.w0Data    = bus.w0Data;
    assign nb.w1En      = bus.w1En;
    assign nb.w1Addr    = bus.w1Addr;
    assign nb.w1Data    = bus.w1Data;
    assign nb.allocEn   = bus.allocEn;
    assign nb.allocAddr = bus.allocAddr;
    function automatic logic [31:0] exp_data(input logic [4:0] a, input bit byp);
        if (a == 0) return 32'h0;
        if (byp && bus.w0En && bus.w0Addr == a) return bus.w0Data;
        if (byp && bus.w1En && bus.w1Addr == a) return bus.w1Data;
        return m_reg[a];
    endfunction
    function automatic logic exp_busy(input logic [4:0] a, input bit byp);
        return m_busy[a] && !(byp && bus.w1En && bus.w1Addr == a);
    endfunction
    task automatic tick();
        @(posedge clk);
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) m_reg[i] = 32'h0;
            m_busy = 32'h0;
        end else begin
            if (bus.w1En && bus.w1Addr != 0) m_reg[bus.w1Addr] = bus.w1Data;
            if (bus.w0En && bus.w0Addr != 0) m_reg[bus.w0Addr] = bus.w0Data;
            if (bus.w1En) m_busy[bus.w1Addr] = 1'b0;
            if (bus.allocEn && bus.allocAddr != 0) m_busy[bus.allocAddr] = 1'b1;
        end
        #1;
    endtask
    task automatic idle();
        bus.w0En = 0;
        bus.w1En = 0;
        bus.allocEn = 0;
    endtask
    task automatic test_reset();
        rst_n = 0;
        tick();
        rst_n = 1;
        for (int a = 0; a < 32; a++) begin
            bus.addrA = 5'(a);
            bus.addrB = 5'(31 - a);
            #1;
            total++;
            if (bus.dataA !== 32'h0 || bus.dataB !== 32'h0 || nb.dataA !== 32'h0 || nb.dataB !== 32'h0) begin
                bad++;
                $display("FAIL reset_data a=%0d got=%h/%h/%h/%h exp=0", a, bus.dataA, bus.dataB, nb.dataA, nb.dataB);
            end
            total++;
            if (bus.busyA !== 1'b0 || bus.busyB !== 1'b0) begin
                bad++;
                $display("FAIL reset_busy a=%0d got=%b%b exp=00", a, bus.busyA, bus.busyB);
            end
        end
        total++;
        if (bus.anyBusy !== 1'b0 || bus.busyCnt !== 6'd0) begin
            bad++;
            $display("FAIL reset_cnt got any=%b cnt=%0d exp any=0 cnt=0", bus.anyBusy, bus.busyCnt);
        end
    endtask
    task automatic test_bypass();
        idle();
        bus.w0En = 1; bus.w0Addr = 5; bus.w0Data = 32'hDEADBEEF; bus.addrA = 5;
        #1;
        total++;
        if (bus.dataA !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL bypass_same got=%h exp=deadbeef", bus.dataA);
        end
        total++;
        if (nb.dataA !== exp_data(5, 0)) begin
            bad++;
            $display("FAIL nobypass_same got=%h exp=%h", nb.dataA, exp_data(5, 0));
        end
        tick();
        idle();
        #1;
        total++;
        if (bus.dataA !== 32'hDEADBEEF || nb.dataA !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL write_after got=%h/%h exp=deadbeef", bus.dataA, nb.dataA);
        end
    endtask
    task automatic test_priority();
        idle();
        bus.w0En = 1; bus.w0Addr = 7; bus.w0Data = 32'h11;
        bus.w1En = 1; bus.w1Addr = 7; bus.w1Data = 32'h22;
        bus.addrA = 7;
        #1;
        total++;
        if (bus.dataA !== 32'h11) begin
            bad++;
            $display("FAIL prio_bypass got=%h exp=11", bus.dataA);
        end
        tick();
        idle();
        bus.w1En = 1; bus.w1Addr = 0; bus.w1Data = 32'hFF; bus.addrB = 0;
        #1;
        total++;
        if (bus.dataB !== 32'h0) begin
            bad++;
            $display("FAIL x0_bypass got=%h exp=0", bus.dataB);
        end
        tick();
        idle();
        #1;
        total++;
        if (bus.dataA !== 32'h11 || nb.dataA !== 32'h11) begin
            bad++;
            $display("FAIL prio_stored got=%h/%h exp=11", bus.dataA, nb.dataA);
        end
        total++;
        if (bus.dataB !== 32'h0 || nb.dataB !== 32'h0) begin
            bad++;
            $display("FAIL x0_stored got=%h/%h exp=0", bus.dataB, nb.dataB);
        end
    endtask
    task automatic test_scoreboard();
        idle();
        bus.allocEn = 1;
        bus.allocAddr = 3; tick();
        bus.allocAddr = 3; tick();
        bus.allocAddr = 9; tick();
        idle();
        bus.addrB = 3;
        #1;
        total++;
        if (bus.busyCnt !== 6'd2 || bus.anyBusy !== 1'b1) begin
            bad++;
            $display("FAIL alloc_cnt got cnt=%0d any=%b exp cnt=2 any=1", bus.busyCnt, bus.anyBusy);
        end
        total++;
        if (bus.busyB !== 1'b1) begin
            bad++;
            $display("FAIL alloc_busy got=%b exp=1", bus.busyB);
        end
        bus.w1En = 1; bus.w1Addr = 3; bus.w1Data = 32'h1234_5678;
        #1;
        total++;
        if (bus.busyB !== 1'b0 || bus.dataB !== 32'h1234_5678) begin
            bad++;
            $display("FAIL load_return got busy=%b data=%h exp busy=0 data=12345678", bus.busyB, bus.dataB);
        end
        total++;
        if (nb.busyB !== 1'b1) begin
            bad++;
            $display("FAIL nobypass_busy got=%b exp=1", nb.busyB);
        end
        tick();
        idle();
        #1;
        total++;
        if (bus.busyCnt !== 6'd1 || bus.busyB !== 1'b0) begin
            bad++;
            $display("FAIL load_clear got cnt=%0d busy=%b exp cnt=1 busy=0", bus.busyCnt, bus.busyB);
        end
    endtask
    task automatic test_alloc_clear();
        logic [5:0] c0;
        idle();
        c0 = bus.busyCnt;
        bus.allocEn = 1; bus.allocAddr = 4;
        bus.w1En = 1; bus.w1Addr = 4; bus.w1Data = 32'hABCD;
        tick();
        idle();
        bus.addrA = 4;
        #1;
        total++;
        if (bus.busyA !== 1'b1 || bus.busyCnt !== 6'($countones(m_busy)) || bus.busyCnt !== c0 + 6'd1) begin
            bad++;
            $display("FAIL alloc_wins got busy=%b cnt=%0d exp busy=1 cnt=%0d", bus.busyA, bus.busyCnt, c0 + 6'd1);
        end
        c0 = bus.busyCnt;
        bus.allocEn = 1; bus.allocAddr = 0;
        tick();
        idle();
        bus.addrA = 0;
        #1;
        total++;
        if (bus.busyCnt !== c0 || bus.busyA !== 1'b0) begin
            bad++;
            $display("FAIL alloc_x0 got cnt=%0d busy=%b exp cnt=%0d busy=0", bus.busyCnt, bus.busyA, c0);
        end
    endtask
    task automatic test_reset_mid();
        idle();
        bus.allocEn = 1;
        bus.allocAddr = 6; tick();
        bus.allocAddr = 8; tick();
        idle();
        rst_n = 0;
        bus.w0En = 1; bus.w0Addr = 6; bus.w0Data = 32'h55;
        tick();
        rst_n = 1;
        idle();
        bus.addrA = 6;
        #1;
        total++;
        if (bus.dataA !== 32'h0 || bus.busyCnt !== 6'd0 || bus.anyBusy !== 1'b0 || bus.busyA !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid got data=%h cnt=%0d any=%b busy=%b exp 0/0/0/0", bus.dataA, bus.busyCnt, bus.anyBusy, bus.busyA);
        end
        bus.w1En = 1; bus.w1Addr = 6; bus.w1Data = 32'h77;
        tick();
        idle();
        #1;
        total++;
        if (bus.dataA !== 32'h77 || bus.busyCnt !== 6'd0) begin
            bad++;
            $display("FAIL late_load got data=%h cnt=%0d exp data=77 cnt=0", bus.dataA, bus.busyCnt);
        end
    endtask
    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            rst_n = ($urandom_range(0, 59) != 0);
            bus.addrA = 5'($urandom_range(0, 9));
            bus.addrB = 5'($urandom_range(0, 9));
            bus.w0En = 1'($urandom); bus.w0Addr = 5'($urandom_range(0, 9)); bus.w0Data = $urandom;
            bus.w1En = 1'($urandom); bus.w1Addr = 5'($urandom_range(0, 9)); bus.w1Data = $urandom;
            bus.allocEn = 1'($urandom); bus.allocAddr = 5'($urandom_range(0, 9));
            #1;
            total++;
            if (bus.dataA !== exp_data(bus.addrA, 1) || bus.dataB !== exp_data(bus.addrB, 1)) begin
                bad++;
                $display("FAIL rnd_data n=%0d got=%h/%h exp=%h/%h", n, bus.dataA, bus.dataB, exp_data(bus.addrA, 1), exp_data(bus.addrB, 1));
            end
            total++;
            if (nb.dataA !== exp_data(bus.addrA, 0) || nb.dataB !== exp_data(bus.addrB, 0)) begin
                bad++;
                $display("FAIL rnd_nb_data n=%0d got=%h/%h exp=%h/%h", n, nb.dataA, nb.dataB, exp_data(bus.addrA, 0), exp_data(bus.addrB, 0));
            end
            total++;
            if (bus.busyA !== exp_busy(bus.addrA, 1) || bus.busyB !== exp_busy(bus.addrB, 1) ||
                nb.busyA !== exp_busy(bus.addrA, 0) || nb.busyB !== exp_busy(bus.addrB, 0)) begin
                bad++;
                $display("FAIL rnd_busy n=%0d got=%b%b%b%b exp=%b%b%b%b", n, bus.busyA, bus.busyB, nb.busyA, nb.busyB,
                         exp_busy(bus.addrA, 1), exp_busy(bus.addrB, 1), exp_busy(bus.addrA, 0), exp_busy(bus.addrB, 0));
            end
            total++;
            if (bus.busyCnt !== 6'($countones(m_busy)) || bus.anyBusy !== (m_busy != 0)) begin
                bad++;
                $display("FAIL rnd_cnt n=%0d got cnt=%0d any=%b exp cnt=%0d any=%b", n, bus.busyCnt, bus.anyBusy, $countones(m_busy), m_busy != 0);
            end
            tick();
        end
        rst_n = 1;
        idle();
    endtask
    initial begin
        bus.addrA = 0; bus.addrB = 0;
        bus.w0Addr = 0; bus.w0Data = 0; bus.w1Addr = 0; bus.w1Data = 0; bus.allocAddr = 0;
        idle();
        m_busy = 32'h0;
        for (int i = 0; i < 32; i++) m_reg[i] = 32'h0;
        #2;
        test_reset();
        test_bypass();
        test_priority();
        test_scoreboard();
        test_alloc_clear();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
